ps2_txfunc: RTL and testbench

PS/2 host-to-device transmitter; the companion of the PS/2 keyboard receiver in the same design.
- Sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) to the keyboard using the host-request protocol.
- Drives the bus only through open-drain enables. The top level maps them onto the inout PS2_CLK/PS2_DAT pins: an enable of 1 pulls the pin low; an enable of 0 releases it (Z).
- The receiver must ignore the bus while oBusy=1.

---
 rtl/ps2_txfunc.sv | 93 +++++++++
 tb/tb_ps2_txfunc.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_txfunc.sv
// ps2_txfunc: PS/2 host-to-device command transmitter driving open-drain pin enables
//   CLOCK, RESET     : system clock, asynchronous active-low reset
//   iCall, iData     : start request (sampled only in IDLE) and command byte
//   PS2_CLK, PS2_DAT : raw pin levels
//   oClkOE, oDatOE   : 1 pulls the corresponding pin low, 0 releases it
//   oBusy            : transfer in progress
//   oDone, oErr      : one-cycle completion pulse, with error flag (no ACK or timeout)
module ps2_txfunc #(
  parameter int T_INHIBIT = 5000,
  parameter int T_SETUP   = 250,
  parameter int T_TIMEOUT = 750000
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       iCall,
  input  logic [7:0] iData,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic       oClkOE,
  output logic       oDatOE,
  output logic       oBusy,
  output logic       oDone,
  output logic       oErr
);
  localparam int T_IS = (T_INHIBIT > T_SETUP) ? T_INHIBIT : T_SETUP;
  localparam int T_MAX = (T_TIMEOUT > T_IS) ? T_TIMEOUT : T_IS;
  localparam int CW = $clog2(T_MAX);
  localparam logic [CW-1:0] INH_END = CW'(T_INHIBIT - 1);
  localparam logic [CW-1:0] SET_END = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] TO_END = CW'(T_TIMEOUT - 1);
  typedef enum logic [2:0] {IDLE, INHIBIT, SETUP, SHIFT, ACK, WAITIDLE, DONE} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt;
  logic [3:0] n;
  logic [9:0] frame;
  logic dat_oe, err;
  logic clk_m, clk_s, clk_p, dat_m, dat_s;
  logic wd, fall, timeout;
  // Falls only matter while the device owns the clock; during INHIBIT/SETUP we pull it low ourselves.
  assign fall = clk_p && !clk_s;
  assign wd = state inside {SHIFT, ACK, WAITIDLE};
  // A fall in the terminal-count cycle wins over the timeout.
  assign timeout = wd && !fall && cnt == TO_END;
  always_ff @(posedge CLOCK or negedge RESET)
    if (!RESET) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    oClkOE = state == INHIBIT || state == SETUP;
    oDatOE = state == SETUP || (state == SHIFT && dat_oe);
    oBusy = !(state == IDLE || state == DONE);
    oDone = state == DONE;
    oErr = state == DONE && err;
    case (state)
      IDLE:     state_d = iCall ? INHIBIT : IDLE;
      INHIBIT:  state_d = (cnt == INH_END) ? SETUP : INHIBIT;
      SETUP:    state_d = (cnt == SET_END) ? SHIFT : SETUP;
      SHIFT:    state_d = (fall && n == 4'd9) ? ACK : timeout ? DONE : SHIFT;
      ACK:      state_d = fall ? WAITIDLE : timeout ? DONE : ACK;
      WAITIDLE: state_d = ((clk_s && dat_s) || timeout) ? DONE : WAITIDLE;
      default:  state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      {clk_m, clk_s, clk_p, dat_m, dat_s} <= '1;
      cnt <= '0;
      n <= '0;
      frame <= '0;
      dat_oe <= 1'b0;
      err <= 1'b0;
    end else begin
      {clk_p, clk_s, clk_m} <= {clk_s, clk_m, PS2_CLK};
      {dat_s, dat_m} <= {dat_m, PS2_DAT};
      cnt <= (state_d != state || (wd && fall) || state == IDLE) ? '0 : cnt + 1'b1;
      if (state == IDLE && iCall) begin
        frame <= {1'b1, ~^iData, iData};
        err <= 1'b0;
      end
      // The start bit stays driven into SHIFT until the device's first fall.
      if (state == SETUP) begin
        n <= '0;
        dat_oe <= 1'b1;
      end
      if (state == SHIFT && fall) begin
        n <= n + 4'd1;
        dat_oe <= ~frame[n];
      end
      if (state == ACK && fall) err <= dat_s;
      if (timeout) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ps2_txfunc.sv
// tb_ps2_txfunc: scoreboard bench for ps2_txfunc with a clocking PS/2 device model
module tb_ps2_txfunc;
  localparam int T_INH = 20;
  localparam int T_SET = 5;
  localparam int T_TO = 200;
  typedef struct {
    logic        err;
    logic [10:0] frame;
    bit          full;
    int          lat;
  } exp_t;
  logic CLOCK, RESET, iCall;
  logic [7:0] iData;
  logic ps2_clk, ps2_dat, oClkOE, oDatOE, oBusy, oDone, oErr;
  logic dev_clk, dev_dat;
  logic [10:0] rx;
  int cyc, last_fall, checks, errors, inh_len, set_len;
  exp_t q[$];
  exp_t mon_e;
  assign ps2_clk = !(oClkOE || dev_clk);
  assign ps2_dat = !(oDatOE || dev_dat);
  ps2_txfunc #(.T_INHIBIT(T_INH), .T_SETUP(T_SET), .T_TIMEOUT(T_TO)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .iCall(iCall), .iData(iData),
    .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat),
    .oClkOE(oClkOE), .oDatOE(oDatOE), .oBusy(oBusy), .oDone(oDone), .oErr(oErr)
  );
  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;
  always @(posedge CLOCK) cyc <= cyc + 1;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Monitor: measures enable phases and checks every oDone against the scoreboard.
  always @(negedge CLOCK) begin
    if (RESET && oDone) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got oDone=1 expected no pending transfer");
      end else begin
        mon_e = q.pop_front();
        chk("err", oErr, mon_e.err);
        chk("enables_released", {oClkOE, oDatOE}, 0);
        chk("busy_at_done", oBusy, 0);
        chk("inhibit_len", inh_len, T_INH);
        chk("setup_len", set_len, T_SET);
        if (mon_e.full) chk("frame", rx, mon_e.frame);
        // 3 = two synchronizer stages plus the edge that registers the fall
        if (mon_e.lat >= 0) chk("timeout_latency", cyc - last_fall, mon_e.lat);
      end
    end
    if (!oBusy) begin
      inh_len = 0;
      set_len = 0;
    end else if (oClkOE && oDatOE) set_len++;
    else if (oClkOE) inh_len++;
  end
  // Device: waits for the host request, then gives nf clock pulses of 40 cycles,
  // sampling on each rise; with ack it pulls data low for the 11th clock.
  task automatic device(input int nf, input bit ack);
    int t;
    t = 0;
    while (!oClkOE && t < 1000) begin @(negedge CLOCK); t++; end
    while (oClkOE && t < 2000) begin @(negedge CLOCK); t++; end
    if (oClkOE || t >= 2000) begin
      checks++;
      errors++;
      $display("FAIL request_wait: got no clock release within %0d cycles", t);
    end
    rx = '0;
    rx[0] = ps2_dat;
    for (int i = 0; i < nf; i++) begin
      repeat (20) @(negedge CLOCK);
      dev_clk = 1'b1;
      last_fall = cyc;
      repeat (20) @(negedge CLOCK);
      dev_clk = 1'b0;
      if (i < 10) rx[i+1] = ps2_dat;
      if (i == 9) dev_dat = ack;
      if (i == 10) dev_dat = 1'b0;
    end
  endtask
  task automatic wait_idle();
    int t;
    t = 0;
    while (oBusy && t < 3000) begin @(negedge CLOCK); t++; end
    if (oBusy) begin
      checks++;
      errors++;
      $display("FAIL busy_wait: got oBusy=1 after %0d cycles expected 0", t);
    end
  endtask
  task automatic push(input logic [7:0] d, input logic par, input logic e_err, input bit full, input int lat);
    exp_t e;
    e.err = e_err;
    e.frame = {1'b1, par, d, 1'b0};
    e.full = full;
    e.lat = lat;
    q.push_back(e);
  endtask
  task automatic call(input logic [7:0] d);
    @(negedge CLOCK);
    iData = d;
    iCall = 1'b1;
    @(negedge CLOCK);
    iCall = 1'b0;
  endtask
  task automatic send(input logic [7:0] d, input logic par, input int nf, input bit ack,
                      input logic e_err, input bit full, input int lat);
    push(d, par, e_err, full, lat);
    call(d);
    device(nf, ack);
    wait_idle();
  endtask
  initial begin
    bit any_busy;
    cyc = 0;
    last_fall = 0;
    checks = 0;
    errors = 0;
    inh_len = 0;
    set_len = 0;
    RESET = 1'b0;
    iCall = 1'b0;
    iData = 8'h00;
    dev_clk = 1'b0;
    dev_dat = 1'b0;
    rx = '0;
    repeat (3) @(negedge CLOCK);
    chk("reset_outputs", {oClkOE, oDatOE, oBusy, oDone, oErr}, 0);
    RESET = 1'b1;
    repeat (2) @(negedge CLOCK);
    send(8'hF4, 1'b0, 11, 1'b1, 1'b0, 1'b1, -1);
    send(8'hED, 1'b1, 11, 1'b1, 1'b0, 1'b1, -1);
    send(8'h02, 1'b0, 11, 1'b1, 1'b0, 1'b1, -1);
    send(8'h55, 1'b1, 11, 1'b0, 1'b1, 1'b1, -1);
    send(8'hAA, 1'b1, 4, 1'b0, 1'b1, 1'b0, T_TO + 3);
    repeat (5) @(negedge CLOCK);
    push(8'h0F, 1'b1, 1'b0, 1'b1, -1);
    call(8'h0F);
    fork
      device(11, 1'b1);
      begin
        repeat (150) @(negedge CLOCK);
        iData = 8'h55;
        iCall = 1'b1;
        @(negedge CLOCK);
        iCall = 1'b0;
      end
    join
    wait_idle();
    any_busy = 1'b0;
    repeat (40) begin
      @(negedge CLOCK);
      any_busy |= oBusy;
    end
    chk("no_queued_call", any_busy, 0);
    call(8'hA0);
    device(3, 1'b0);
    chk("pre_reset_shift", {oClkOE, oDatOE, oBusy}, 3'b011);
    #1 RESET = 1'b0;
    #1 chk("async_reset_release", {oClkOE, oDatOE, oBusy}, 0);
    repeat (3) @(negedge CLOCK);
    RESET = 1'b1;
    repeat (3) @(negedge CLOCK);
    send(8'hFF, 1'b1, 11, 1'b1, 1'b0, 1'b1, -1);
    repeat (5) @(negedge CLOCK);
    chk("scoreboard_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
